dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the byte-address width of the shared data memory (depth 2^(ADDR_WIDTH-2) words).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have, per port p in {0,1} (0 = CPU MEM stage, 1 = loader/DMA): req_p input 1 request; we_p input 1 write; addr_p input 32 byte address; wdata_p input 32 write data; be_p input 4 byte enables (bit i = byte i, little-endian).
REQ-005 SHALL have, per port p: gnt_p output 1 request accepted this cycle; rsp_valid_p output 1 response valid; rsp_rdata_p output 32 read data; rsp_err_p output 1 access error.
REQ-006 SHALL have memory side: mem_we output 1; mem_addr output 32; mem_wdata output 32; mem_rdata input 32 (combinational read of mem_addr, write at clk edge when mem_we).

Function
REQ-007 SHALL accept at most one request per cycle; gnt_p combinational, asserted only when req_p=1 and reset=0.
REQ-008 SHALL arbitrate round-robin: one requester -> it wins; both -> the port not granted most recently wins.
REQ-009 SHALL update last-granted pointer at the edge ending any cycle with a grant; unchanged otherwise.
REQ-010 SHALL drive mem_addr = addr of granted port, 0 when no grant.
REQ-011 SHALL classify a granted access as error if addr[1:0]!=0, or addr[31:ADDR_WIDTH]!=0, or be=0.
REQ-012 SHALL assert mem_we only for a granted, non-error write.
REQ-013 SHALL form mem_wdata by byte merge: byte i = wdata byte i if be[i]=1, else mem_rdata byte i (single-cycle read-modify-write).
REQ-014 SHALL perform no memory write for reads, errors, or cycles without grant.
REQ-015 SHALL assert rsp_valid_p for exactly one cycle, the cycle after gnt_p, for both reads and writes.
REQ-016 SHALL register rsp_rdata_p = mem_rdata sampled in the grant cycle for non-error reads; 0 for writes and errors.
REQ-017 SHALL register rsp_err_p = error classification of the granted access; 0 when rsp_valid_p=0.
REQ-018 SHALL hold rsp_rdata_p stable until that port's next response.
REQ-019 SHALL support back-to-back grants to the same port every cycle when only it requests (throughput 1 access/cycle).
REQ-020 SHALL, on read-after-write to the same word in consecutive cycles, return the newly written data (memory written at first edge).
REQ-021 SHALL ignore requester inputs of non-granted ports; requesters keep req/addr/data stable until gnt.

Reset
REQ-022 SHALL, while reset=1, force gnt_0=gnt_1=0 and mem_we=0; no write occurs in a reset cycle.
REQ-023 SHALL, at reset edge, clear rsp_valid_p, rsp_rdata_p, rsp_err_p to 0 and set last-granted pointer to 1 (port 0 wins first tie).
REQ-024 SHALL discard a response pending when reset asserts (rsp_valid stays 0 after reset edge).

Verification
REQ-025 Reset, then both ports request reads of 0x0 and 0x4 every cycle -> grants alternate 0,1,0,1; each rsp_valid one cycle after its gnt.
REQ-026 Port 0 writes 0x11223344 to 0x10 be=1111, next cycle reads 0x10 -> rsp_rdata_0=0x11223344, rsp_err_0=0.
REQ-027 Word 0x20 holds 0xAABBCCDD; port 1 writes wdata 0x000000EE be=0001 -> word becomes 0xAABBCCEE.
REQ-028 Port 0 write to 0x13 (misaligned), 0x1000 (ADDR_WIDTH=12, out of range), be=0 -> mem_we=0 each, rsp_err_0=1, rsp_rdata_0=0, memory unchanged.
REQ-029 Only port 1 requests 4 consecutive cycles -> gnt_1=1 all 4 cycles, 4 consecutive rsp_valid_1 pulses.
REQ-030 Assert reset in cycle after a granted write -> rsp_valid stays 0, pointer restored, next tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Sub-word writes are merged with the current word in the grant cycle.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_0,
    input  logic        we_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    input  logic [3:0]  be_0,
    output logic        gnt_0,
    output logic        rsp_valid_0,
    output logic [31:0] rsp_rdata_0,
    output logic        rsp_err_0,

    input  logic        req_1,
    input  logic        we_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    input  logic [3:0]  be_1,
    output logic        gnt_1,
    output logic        rsp_valid_1,
    output logic [31:0] rsp_rdata_1,
    output logic        rsp_err_1,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // last_q = 1 means port 1 was granted most recently
    logic        last_q, last_d;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        acc_err;
    logic [31:0] merged;
    logic [31:0] rd_data;

    logic        vld0_q, vld0_d;
    logic        err0_q, err0_d;
    logic [31:0] rd0_q, rd0_d;
    logic        vld1_q, vld1_d;
    logic        err1_q, err1_d;
    logic [31:0] rd1_q, rd1_d;

    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (!reset) begin
            if (req_0 && req_1) begin
                gnt_0 = last_q;
                gnt_1 = ~last_q;
            end else begin
                gnt_0 = req_0;
                gnt_1 = req_1;
            end
        end
    end

    assign any_gnt = gnt_0 | gnt_1;

    always_comb begin
        sel_we    = we_0;
        sel_addr  = addr_0;
        sel_wdata = wdata_0;
        sel_be    = be_0;
        if (gnt_1) begin
            sel_we    = we_1;
            sel_addr  = addr_1;
            sel_wdata = wdata_1;
            sel_be    = be_1;
        end
    end

    always_comb begin
        acc_err = 1'b0;
        if (any_gnt) begin
            acc_err = (sel_addr[1:0] != 2'b00)
                    | (|sel_addr[31:ADDR_WIDTH])
                    | (sel_be == 4'b0000);
        end
    end

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (sel_be[i]) begin
                merged[8*i +: 8] = sel_wdata[8*i +: 8];
            end
        end
    end

    assign mem_we    = any_gnt & sel_we & ~acc_err;
    assign mem_addr  = any_gnt ? sel_addr : 32'd0;
    assign mem_wdata = mem_we ? merged : 32'd0;
    assign rd_data   = (sel_we | acc_err) ? 32'd0 : mem_rdata;

    always_comb begin
        last_d = last_q;
        if (gnt_1) begin
            last_d = 1'b1;
        end else if (gnt_0) begin
            last_d = 1'b0;
        end
    end

    always_comb begin
        vld0_d = gnt_0;
        err0_d = gnt_0 & acc_err;
        rd0_d  = gnt_0 ? rd_data : rd0_q;
        vld1_d = gnt_1;
        err1_d = gnt_1 & acc_err;
        rd1_d  = gnt_1 ? rd_data : rd1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
            vld0_q <= 1'b0;
            err0_q <= 1'b0;
            rd0_q  <= 32'd0;
            vld1_q <= 1'b0;
            err1_q <= 1'b0;
            rd1_q  <= 32'd0;
        end else begin
            last_q <= last_d;
            vld0_q <= vld0_d;
            err0_q <= err0_d;
            rd0_q  <= rd0_d;
            vld1_q <= vld1_d;
            err1_q <= err1_d;
            rd1_q  <= rd1_d;
        end
    end

    // A response still pending when reset rises is suppressed immediately
    assign rsp_valid_0 = vld0_q & ~reset;
    assign rsp_err_0   = err0_q & ~reset;
    assign rsp_rdata_0 = rd0_q;
    assign rsp_valid_1 = vld1_q & ~reset;
    assign rsp_err_1   = err1_q & ~reset;
    assign rsp_rdata_1 = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus directed scenarios.
module tb_dmem_arbiter;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];

    logic        gnt_0, rsp_valid_0, rsp_err_0;
    logic        gnt_1, rsp_valid_1, rsp_err_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] bmem [1024];

    int n_cmp = 0;
    int n_bad = 0;

    int          m_last;
    logic [31:0] m_mem [1024];
    logic        m_vld [2];
    logic        m_er [2];
    logic [31:0] m_rd [2];
    bit          known = 0;

    logic [31:0] e_addr [3];
    logic [3:0]  e_be [3];

    dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_0(req[0]), .we_0(we[0]), .addr_0(addr[0]),
        .wdata_0(wdata[0]), .be_0(be[0]),
        .gnt_0(gnt_0), .rsp_valid_0(rsp_valid_0),
        .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
        .req_1(req[1]), .we_1(we[1]), .addr_1(addr[1]),
        .wdata_1(wdata[1]), .be_1(be[1]),
        .gnt_1(gnt_1), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = bmem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: decide winner, classify, predict memory and responses
    always @(negedge clk) begin : cmp
        int g;
        int idx;
        logic [31:0] a;
        logic [31:0] nw;
        logic e;
        logic ew;
        g = -1;
        if (!reset) begin
            if (req[0] && req[1]) g = (m_last == 0) ? 1 : 0;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end
        a = (g >= 0) ? addr[g] : 32'd0;
        e = 1'b0;
        ew = 1'b0;
        nw = 32'd0;
        idx = int'(a[11:2]);
        if (g >= 0) begin
            e = (a % 4 != 0) || (a >= (32'd1 << AW)) || (be[g] == 4'd0);
            ew = we[g] && !e;
            nw = m_mem[idx];
            for (int i = 0; i < 4; i++) begin
                if (be[g][i]) nw[8*i +: 8] = wdata[g][8*i +: 8];
            end
        end
        chk("m_gnt0", {31'd0, gnt_0}, {31'd0, g == 0});
        chk("m_gnt1", {31'd0, gnt_1}, {31'd0, g == 1});
        chk("m_mem_addr", mem_addr, a);
        chk("m_mem_we", {31'd0, mem_we}, {31'd0, ew});
        if (ew) chk("m_mem_wdata", mem_wdata, nw);
        if (known) begin
            chk("m_vld0", {31'd0, rsp_valid_0}, {31'd0, m_vld[0] && !reset});
            chk("m_err0", {31'd0, rsp_err_0}, {31'd0, m_er[0] && !reset});
            chk("m_rd0", rsp_rdata_0, m_rd[0]);
            chk("m_vld1", {31'd0, rsp_valid_1}, {31'd0, m_vld[1] && !reset});
            chk("m_err1", {31'd0, rsp_err_1}, {31'd0, m_er[1] && !reset});
            chk("m_rd1", rsp_rdata_1, m_rd[1]);
        end
        if (reset) begin
            known = 1;
            m_last = 1;
            for (int p = 0; p < 2; p++) begin
                m_vld[p] = 0;
                m_er[p] = 0;
                m_rd[p] = 32'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_vld[p] = (g == p);
                m_er[p] = (g == p) && e;
            end
            if (g >= 0) begin
                m_rd[g] = (we[g] || e) ? 32'd0 : m_mem[idx];
                m_last = g;
                if (ew) m_mem[idx] = nw;
            end
        end
    end

    task automatic setp(int p, logic r, logic w, logic [31:0] ad,
                        logic [31:0] wd, logic [3:0] b);
        req[p] = r;
        we[p] = w;
        addr[p] = ad;
        wdata[p] = wd;
        be[p] = b;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            setp(p, 0, 0, 32'd0, 32'd0, 4'd0);
            m_vld[p] = 0;
            m_er[p] = 0;
            m_rd[p] = 32'd0;
        end
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
            m_mem[i] = bmem[i];
        end
        bmem[8] = 32'hAABBCCDD;
        m_mem[8] = 32'hAABBCCDD;

        reset = 1'b1;
        cyc;
        cyc;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_vld0", {31'd0, rsp_valid_0}, 32'd0);
        chk("rst_rd1", rsp_rdata_1, 32'd0);
        cyc;

        setp(0, 1, 0, 32'h0, 32'd0, 4'hF);
        setp(1, 1, 0, 32'h4, 32'd0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt0", {31'd0, gnt_0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", {31'd0, gnt_1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk("rr_vld", {31'd0, (k % 2 == 1) ? rsp_valid_0 : rsp_valid_1}, 32'd1);
            end
            cyc;
        end
        setp(0, 0, 0, 32'h0, 32'd0, 4'hF);
        setp(1, 0, 0, 32'h4, 32'd0, 4'hF);
        @(negedge clk);
        chk("rr_last_vld1", {31'd0, rsp_valid_1}, 32'd1);
        cyc;

        setp(0, 1, 1, 32'h10, 32'h11223344, 4'hF);
        @(negedge clk);
        chk("raw_we", {31'd0, mem_we}, 32'd1);
        chk("raw_wdata", mem_wdata, 32'h11223344);
        cyc;
        setp(0, 1, 0, 32'h10, 32'd0, 4'hF);
        @(negedge clk);
        chk("raw_wr_rsp", rsp_rdata_0, 32'd0);
        cyc;
        setp(0, 0, 0, 32'h10, 32'd0, 4'hF);
        @(negedge clk);
        chk("raw_rdata", rsp_rdata_0, 32'h11223344);
        chk("raw_err", {31'd0, rsp_err_0}, 32'd0);
        cyc;

        setp(1, 1, 1, 32'h20, 32'h000000EE, 4'b0001);
        @(negedge clk);
        chk("merge_wdata", mem_wdata, 32'hAABBCCEE);
        cyc;
        setp(1, 1, 0, 32'h20, 32'd0, 4'hF);
        cyc;
        setp(1, 0, 0, 32'h20, 32'd0, 4'hF);
        @(negedge clk);
        chk("merge_rd", rsp_rdata_1, 32'hAABBCCEE);
        cyc;

        e_addr[0] = 32'h13;
        e_be[0] = 4'hF;
        e_addr[1] = 32'h1000;
        e_be[1] = 4'hF;
        e_addr[2] = 32'h10;
        e_be[2] = 4'h0;
        for (int k = 0; k < 3; k++) begin
            setp(0, 1, 1, e_addr[k], 32'hDEADBEEF, e_be[k]);
            @(negedge clk);
            chk("err_we", {31'd0, mem_we}, 32'd0);
            cyc;
            setp(0, 0, 0, 32'h0, 32'd0, 4'hF);
            @(negedge clk);
            chk("err_flag", {31'd0, rsp_err_0}, 32'd1);
            chk("err_rd", rsp_rdata_0, 32'd0);
            cyc;
        end
        setp(0, 1, 0, 32'h10, 32'd0, 4'hF);
        cyc;
        setp(0, 0, 0, 32'h0, 32'd0, 4'hF);
        @(negedge clk);
        chk("err_unchanged", rsp_rdata_0, 32'h11223344);
        cyc;

        for (int k = 0; k < 4; k++) begin
            setp(1, 1, 0, 32'(4 * k), 32'd0, 4'hF);
            @(negedge clk);
            chk("b2b_gnt1", {31'd0, gnt_1}, 32'd1);
            if (k > 0) chk("b2b_vld1", {31'd0, rsp_valid_1}, 32'd1);
            cyc;
        end
        setp(1, 0, 0, 32'h0, 32'd0, 4'hF);
        @(negedge clk);
        chk("b2b_last_vld", {31'd0, rsp_valid_1}, 32'd1);
        chk("b2b_rd", rsp_rdata_1, 32'h59590303);
        cyc;
        @(negedge clk);
        chk("b2b_idle", {31'd0, rsp_valid_1}, 32'd0);
        cyc;

        setp(0, 1, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("rstw_gnt0", {31'd0, gnt_0}, 32'd1);
        cyc;
        reset = 1'b1;
        setp(0, 1, 0, 32'h0, 32'd0, 4'hF);
        setp(1, 1, 0, 32'h4, 32'd0, 4'hF);
        @(negedge clk);
        chk("rstw_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
        chk("rstw_we", {31'd0, mem_we}, 32'd0);
        chk("rstw_vld", {31'd0, rsp_valid_0}, 32'd0);
        cyc;
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_vld_after", {31'd0, rsp_valid_0}, 32'd0);
        chk("rstw_tie0", {31'd0, gnt_0}, 32'd1);
        cyc;
        @(negedge clk);
        chk("rstw_tie1", {31'd0, gnt_1}, 32'd1);
        cyc;
        setp(1, 0, 0, 32'h4, 32'd0, 4'hF);
        setp(0, 1, 0, 32'h30, 32'd0, 4'hF);
        cyc;
        setp(0, 0, 0, 32'h0, 32'd0, 4'hF);
        @(negedge clk);
        chk("rstw_mem", rsp_rdata_0, 32'hCAFEF00D);
        cyc;
        cyc;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
